// File: rtl/radon_axil_slave_regs.sv
// AXI4-Lite register slave for the Radon IP: NUM_REGS read/write words
// exported to the core, with a one-cycle strobe per committed register write.
module radon_axil_slave_regs #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 4
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic [ADDR_WIDTH-1:0]    S_AXI_AWADDR,
    input  logic [2:0]               S_AXI_AWPROT,
    input  logic                     S_AXI_AWVALID,
    output logic                     S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]    S_AXI_WDATA,
    input  logic [3:0]               S_AXI_WSTRB,
    input  logic                     S_AXI_WVALID,
    output logic                     S_AXI_WREADY,
    output logic [1:0]               S_AXI_BRESP,
    output logic                     S_AXI_BVALID,
    input  logic                     S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]    S_AXI_ARADDR,
    input  logic [2:0]               S_AXI_ARPROT,
    input  logic                     S_AXI_ARVALID,
    output logic                     S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]    S_AXI_RDATA,
    output logic [1:0]               S_AXI_RRESP,
    output logic                     S_AXI_RVALID,
    input  logic                     S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]   REG_OUT,
    output logic [NUM_REGS-1:0]      REG_WSTB
);
    localparam int          IDX_W  = ADDR_WIDTH - 2;
    localparam logic [31:0] NREGS  = NUM_REGS;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    logic                  run;
    logic                  aw_held;
    logic                  w_held;
    logic [IDX_W-1:0]      aw_idx_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [3:0]            w_strb_q;
    logic [31:0]           regs [NUM_REGS];
    logic                  bvalid;
    logic [1:0]            bresp;
    logic                  rvalid;
    logic [1:0]            rresp;
    logic [DATA_WIDTH-1:0] rdata;
    logic [NUM_REGS-1:0]   wstb;

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [3:0]            wr_strb;
    logic                  wr_in_range, rd_in_range;
    logic [31:0]           rd_word;
    logic                  unused_ok;

    // run keeps all READY outputs low until the first edge after reset release
    assign S_AXI_AWREADY = run && !aw_held && !bvalid;
    assign S_AXI_WREADY  = run && !w_held && !bvalid;
    assign S_AXI_ARREADY = run && !rvalid;

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign commit = (aw_held || aw_hs) && (w_held || w_hs);

    assign wr_idx      = aw_held ? aw_idx_q : S_AXI_AWADDR[ADDR_WIDTH-1:2];
    assign wr_data     = w_held ? w_data_q : S_AXI_WDATA;
    assign wr_strb     = w_held ? w_strb_q : S_AXI_WSTRB;
    assign wr_in_range = 32'(wr_idx) < NREGS;
    assign rd_idx      = S_AXI_ARADDR[ADDR_WIDTH-1:2];
    assign rd_in_range = 32'(rd_idx) < NREGS;

    assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        rd_word = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++)
            if (32'(rd_idx) == k) rd_word = regs[k];
    end

    always_comb begin
        REG_OUT = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++)
            REG_OUT[32*k +: 32] = regs[k];
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            run      <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bvalid   <= 1'b0;
            bresp    <= OKAY;
            wstb     <= '0;
            for (int unsigned k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else begin
            run  <= 1'b1;
            wstb <= '0;
            if (S_AXI_BREADY) bvalid <= 1'b0;
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_in_range ? OKAY : SLVERR;
                for (int unsigned k = 0; k < NUM_REGS; k++) begin
                    if (wr_in_range && 32'(wr_idx) == k) begin
                        wstb[k] <= 1'b1;
                        for (int unsigned b = 0; b < 4; b++)
                            if (wr_strb[b]) regs[k][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end else begin
                if (aw_hs) begin
                    aw_held  <= 1'b1;
                    aw_idx_q <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= S_AXI_WDATA;
                    w_strb_q <= S_AXI_WSTRB;
                end
            end
        end
    end

    // regs is sampled before this edge's commit lands, so a same-edge read sees the old value
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rvalid <= 1'b0;
            rresp  <= OKAY;
            rdata  <= '0;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rresp  <= rd_in_range ? OKAY : SLVERR;
            rdata  <= rd_in_range ? rd_word : '0;
        end else if (S_AXI_RREADY) begin
            rvalid <= 1'b0;
        end
    end

    assign S_AXI_BVALID = bvalid;
    assign S_AXI_BRESP  = bresp;
    assign S_AXI_RVALID = rvalid;
    assign S_AXI_RRESP  = rresp;
    assign S_AXI_RDATA  = rdata;
    assign REG_WSTB     = wstb;

endmodule

// File: tb/tb_radon_axil_slave_regs.sv
// Bench for radon_axil_slave_regs: vector table, handshake corner sequences,
// then randomized traffic against an array model of the register file.
module tb_radon_axil_slave_regs;
    logic         clk, rst_n;
    logic [5:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb, reg_wstb;
    logic [1:0]   bresp, rresp;
    logic [127:0] reg_out;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] mdl [4];

    radon_axil_slave_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_REGS(4)) dut (
        .ACLK(clk), .ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .REG_OUT(reg_out), .REG_WSTB(reg_wstb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    function automatic void model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        idx = int'(a) / 4;
        if (idx < 4)
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
    endfunction

    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly,
                            output logic [1:0] resp, output logic [3:0] stb);
        logic aw_done, w_done, hs_aw, hs_w;
        int c;
        aw_done = 1'b0; w_done = 1'b0; c = 0; stb = '0; resp = 2'b11;
        awaddr = a; wdata = d; wstrb = s;
        while (!(aw_done && w_done)) begin
            awvalid = !aw_done && c >= aw_dly;
            wvalid  = !w_done && c >= w_dly;
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge clk); #1;
            aw_done = aw_done || hs_aw;
            w_done  = w_done || hs_w;
            stb |= reg_wstb;
            c++;
            if (c > 40) begin
                timeout("write_addr_data");
                break;
            end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        c = 0;
        while (!bvalid && c < 40) begin
            @(posedge clk); #1;
            stb |= reg_wstb;
            c++;
        end
        if (!bvalid) timeout("write_resp");
        resp = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        stb |= reg_wstb;
    endtask

    task automatic do_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
        logic hs;
        int c;
        hs = 1'b0; c = 0;
        araddr = a; arvalid = 1'b1;
        while (!hs) begin
            hs = arready;
            @(posedge clk); #1;
            c++;
            if (c > 40 && !hs) begin
                timeout("read_addr");
                break;
            end
        end
        arvalid = 1'b0;
        c = 0;
        while (!rvalid && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
        if (!rvalid) timeout("read_data");
        d = rdata; resp = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    typedef struct {
        bit          is_wr;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        logic [3:0]  exp_stb;
    } vec_t;

    vec_t        vec [16];
    logic [1:0]  resp;
    logic [3:0]  stb;
    logic [31:0] rd;
    logic [31:0] exp_rd;

    initial begin
        vec[0]  = '{1, 6'h00, 32'h00000001, 4'hF, 32'h0,        2'b00, 4'b0001};
        vec[1]  = '{1, 6'h04, 32'h00000002, 4'hF, 32'h0,        2'b00, 4'b0010};
        vec[2]  = '{1, 6'h08, 32'h00000003, 4'hF, 32'h0,        2'b00, 4'b0100};
        vec[3]  = '{1, 6'h0C, 32'h00000004, 4'hF, 32'h0,        2'b00, 4'b1000};
        vec[4]  = '{0, 6'h00, 32'h0,        4'h0, 32'h00000001, 2'b00, 4'b0000};
        vec[5]  = '{0, 6'h04, 32'h0,        4'h0, 32'h00000002, 2'b00, 4'b0000};
        vec[6]  = '{0, 6'h08, 32'h0,        4'h0, 32'h00000003, 2'b00, 4'b0000};
        vec[7]  = '{0, 6'h0C, 32'h0,        4'h0, 32'h00000004, 2'b00, 4'b0000};
        vec[8]  = '{1, 6'h04, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b00, 4'b0010};
        vec[9]  = '{1, 6'h05, 32'h12345678, 4'h5, 32'h0,        2'b00, 4'b0010};
        vec[10] = '{0, 6'h04, 32'h0,        4'h0, 32'hFF34FF78, 2'b00, 4'b0000};
        vec[11] = '{1, 6'h20, 32'hAAAAAAAA, 4'hF, 32'h0,        2'b10, 4'b0000};
        vec[12] = '{0, 6'h20, 32'h0,        4'h0, 32'h00000000, 2'b10, 4'b0000};
        vec[13] = '{1, 6'h0C, 32'h55555555, 4'h0, 32'h0,        2'b00, 4'b1000};
        vec[14] = '{0, 6'h0C, 32'h0,        4'h0, 32'h00000004, 2'b00, 4'b0000};
        vec[15] = '{0, 6'h3C, 32'h0,        4'h0, 32'h00000000, 2'b10, 4'b0000};

        rst_n = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < 4; i++) mdl[i] = '0;

        // reset state
        #2 rst_n = 1'b0;
        #1;
        check("reset_ready", {awready, wready, arready}, 3'b000);
        check("reset_valid", {bvalid, rvalid}, 2'b00);
        check("reset_resp", {bresp, rresp}, 4'b0000);
        check("reset_rdata", rdata, 32'h0);
        check("reset_reg_out", reg_out, 128'h0);
        check("reset_wstb", reg_wstb, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        check("ready_held_in_reset", {awready, wready, arready}, 3'b000);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", {awready, wready, arready}, 3'b000);
        @(posedge clk); #1;
        check("ready_after_release", {awready, wready, arready}, 3'b111);

        // vector table
        for (int i = 0; i < 16; i++) begin
            if (vec[i].is_wr) begin
                do_write(vec[i].addr, vec[i].data, vec[i].strb, 0, 0, resp, stb);
                model_write(vec[i].addr, vec[i].data, vec[i].strb);
                check($sformatf("vec%0d_bresp", i), resp, vec[i].exp_resp);
                check($sformatf("vec%0d_wstb", i), stb, vec[i].exp_stb);
            end else begin
                do_read(vec[i].addr, rd, resp);
                check($sformatf("vec%0d_rdata", i), rd, vec[i].exp_data);
                check($sformatf("vec%0d_rresp", i), resp, vec[i].exp_resp);
            end
        end
        check("table_reg_out", reg_out, 128'h00000004_00000003_FF34FF78_00000001);

        // W presented three cycles before AW
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        check("early_w_wready", wready, 1'b1);
        @(posedge clk); #1;
        wvalid = 1'b0;
        check("wready_drops_held", wready, 1'b0);
        check("no_bvalid_w_only", bvalid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        awaddr = 6'h08; awvalid = 1'b1;
        check("late_aw_awready", awready, 1'b1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        model_write(6'h08, 32'hDEADBEEF, 4'hF);
        check("late_aw_bvalid", bvalid, 1'b1);
        check("late_aw_wstb", reg_wstb, 4'b0100);
        @(posedge clk); #1;
        check("wstb_one_cycle", reg_wstb, 4'b0000);
        check("bvalid_holds", bvalid, 1'b1);
        check("late_aw_reg2", reg_out[95:64], mdl[2]);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("late_aw_bclear", bvalid, 1'b0);

        // same-edge write and read of reg 3, then 5 cycles of B/R backpressure
        awaddr = 6'h0C; wdata = 32'h11111111; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 6'h0C; arvalid = 1'b1;
        exp_rd = mdl[3];
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        model_write(6'h0C, 32'h11111111, 4'hF);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d_flags", i), {bvalid, rvalid, awready, wready, arready}, 5'b11000);
            check($sformatf("stall%0d_rdata", i), rdata, exp_rd);
            check($sformatf("stall%0d_resp", i), {bresp, rresp}, 4'b0000);
            @(posedge clk); #1;
        end
        check("stall_reg3", reg_out[127:96], mdl[3]);
        bready = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;
        check("stall_release", {bvalid, rvalid, awready, wready, arready}, 5'b00111);

        // reset while BVALID is pending
        awaddr = 6'h04; wdata = 32'h77777777; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("pre_reset_bvalid", bvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) mdl[i] = '0;
        check("async_bvalid", bvalid, 1'b0);
        check("async_reg_out", reg_out, 128'h0);
        check("async_ready", {awready, wready, arready}, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("no_b_after_reset%0d", i), bvalid, 1'b0);
        end
        bready = 1'b0;
        do_write(6'h08, 32'h0BADCAFE, 4'hF, 0, 0, resp, stb);
        model_write(6'h08, 32'h0BADCAFE, 4'hF);
        check("post_reset_bresp", resp, 2'b00);
        check("post_reset_wstb", stb, 4'b0100);
        do_read(6'h08, rd, resp);
        check("post_reset_rdata", rd, 32'h0BADCAFE);

        // randomized traffic against the array model
        for (int i = 0; i < 60; i++) begin
            logic [5:0]  a;
            logic [31:0] d;
            logic [3:0]  s;
            int idx;
            a = ($urandom_range(0, 3) != 0) ? 6'($urandom_range(0, 15)) : 6'($urandom_range(0, 63));
            d = $urandom;
            s = 4'($urandom);
            idx = int'(a) / 4;
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), resp, stb);
                model_write(a, d, s);
                check($sformatf("rnd%0d_bresp", i), resp, (idx < 4) ? 2'b00 : 2'b10);
                check($sformatf("rnd%0d_wstb", i), stb, (idx < 4) ? 4'(1 << idx) : 4'b0000);
            end else begin
                do_read(a, rd, resp);
                check($sformatf("rnd%0d_rdata", i), rd, (idx < 4) ? mdl[idx] : 32'h0);
                check($sformatf("rnd%0d_rresp", i), resp, (idx < 4) ? 2'b00 : 2'b10);
            end
        end
        check("final_reg_out", reg_out, {mdl[3], mdl[2], mdl[1], mdl[0]});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/radon_axil_slave_regs.md
Name: radon_axil_slave_regs

Overview:
- AXI4-Lite responder (slave) that terminates the control bus of the Radon IP.
- Holds NUM_REGS 32-bit read/write registers and exports them to the Radon core.
- Produces a one-cycle write strobe per register so the core can react to control writes.
- Serves the Master VIP 4-register sequential write/read-back sequence and any compliant AXI4-Lite master.

Parameters:
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- ADDR_WIDTH, 4, AXI address width in bits; must be at least clog2(NUM_REGS*4).
- NUM_REGS, 4, number of 32-bit registers, word-aligned from offset 0x0.

Ports:
- ACLK  in  1  bus clock; all logic is on the rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1 / 1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1 / 1  write-data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1 / 1  write-response handshake.
- S_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1 / 1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1 / 1  read-data handshake.
- REG_OUT  out  NUM_REGS*32  register contents; register k is at bits [32k+31:32k].
- REG_WSTB  out  NUM_REGS  one-cycle pulse, bit k set on the cycle after register k commits.

Behaviour:
- Reset (ARESETN low, asynchronous): all registers, REG_WSTB, BVALID, RVALID, RDATA and the holding flags go to 0. BRESP and RRESP reset to 00. AWREADY, WREADY and ARREADY are 0 while reset is asserted and go to 1 on the first edge after release.
- Reset mid-transaction: in-flight AW, W, B and R state is discarded. No response is issued after reset.
- Address decode: index = addr[ADDR_WIDTH-1:2]; addr[1:0] is ignored. An index >= NUM_REGS is out of range.
- Write path, address and data accepted independently:
  - AWREADY = !aw_held && !BVALID. On an AW handshake the address is latched and aw_held is set.
  - WREADY = !w_held && !BVALID. On a W handshake WDATA/WSTRB are latched and w_held is set.
  - Commit occurs on the edge where address and data are both available (held, or handshaking that same edge). At that edge:
    - bytes with WSTRB[b]=1 are written; bytes with WSTRB[b]=0 keep their value;
    - BVALID is set; BRESP = 00 (OKAY) in range, 10 (SLVERR) out of range, with no register change when out of range;
    - aw_held and w_held are cleared.
  - AW and W handshaking in the same cycle: BVALID is high the next cycle (1-cycle latency).
  - BVALID holds with a stable BRESP until BREADY. No new AW or W is accepted while BVALID is high.
- Read path:
  - ARREADY = !RVALID.
  - On an AR handshake edge: RDATA is loaded with the register value (0 if out of range), RRESP = 00 or 10, and RVALID is set. RVALID is visible the next cycle.
  - RDATA and RRESP are stable until RREADY; RVALID clears on the handshake edge.
- Simultaneous write commit and read of the same register on one edge: the read returns the pre-write value.
- Read and write channels are fully independent: no ordering is imposed between them.
- REG_WSTB[k] pulses for exactly one cycle after each committed in-range write to register k, including writes with WSTRB = 0000.
- At most one outstanding write and one outstanding read. No ID and no bursts.

Test Plan:
- Reset, then write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read back -> RDATA 0x1..0x4, all BRESP/RRESP = 00, REG_OUT = 0x00000004_00000003_00000002_00000001.
- Present W three cycles before AW (WDATA 0xDEADBEEF, address 0x8) -> WREADY drops after W is accepted; BVALID rises 1 cycle after the AW handshake; register 2 = 0xDEADBEEF; REG_WSTB = 0100 pulses for one cycle.
- Register 1 = 0xFFFFFFFF, write 0x12345678 with WSTRB 0101 -> register 1 reads 0xFF34FF78.
- Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID and BRESP/RDATA stay stable; AWREADY, WREADY and ARREADY stay 0 until the handshake completes.
- With ADDR_WIDTH = 6, write and read 0x20 -> BRESP = 10, RRESP = 10, RDATA = 0, no register changes.
- Assert ARESETN low while BVALID is pending -> BVALID = 0 immediately, all registers 0, no B beat after release; the next write completes normally.
